pipe_scroller: RTL and testbench

- Consumes the 8-bit column patterns from the pattern generator and scrolls them right-to-left across a COLS-wide, 8-row playfield at the game tick rate.
- Injects one new pipe column every PIPE_SPACING scroll steps.
- Drives the display grid, the bird-column probe used by collision logic, and a pipe-passed pulse used by the score counter.
- Sits between the pattern generator and the display, collision and score blocks.

---
 rtl/pipe_scroller_if.sv | 32 +++
 rtl/pipe_scroller.sv | 113 +++++++++++
 tb/tb_pipe_scroller.sv | 193 +++++++++++++++++++
 3 files changed

// File: rtl/pipe_scroller_if.sv
// pipe_scroller_if: groups the game-control inputs and the playfield outputs
// of the pipe scroller.
//   start, halt, pattern : game-side controls and generator pattern (master drives)
//   grid, probe          : playfield, column 0 in the low byte; probe = column 0
//   passed, step         : one-cycle pulses following a scroll step
//   running              : high while the scroller is in RUN
//   dbg_state            : current FSM state, for observation only
// Valid/ready is not used here: every signal is a level or a single-cycle pulse
// that is sampled on the rising clock edge. There is no backpressure.
interface pipe_scroller_if #(
    parameter int COLS = 8
);
    logic                start;
    logic                halt;
    logic [7:0]          pattern;
    logic [8*COLS-1:0]   grid;
    logic [7:0]          probe;
    logic                passed;
    logic                step;
    logic                running;
    logic [1:0]          dbg_state;

    modport master (
        output start, halt, pattern,
        input  grid, probe, passed, step, running, dbg_state
    );

    modport slave (
        input  start, halt, pattern,
        output grid, probe, passed, step, running, dbg_state
    );
endinterface

// File: rtl/pipe_scroller.sv
// pipe_scroller: scrolls generator column patterns right-to-left across a
// COLS-wide, 8-row playfield. One scroll step happens every TICK_DIV cycles
// while running. A pipe column is injected every PIPE_SPACING steps.
//   Clock : system clock
//   reset : synchronous, active-high reset
//   bus   : pipe_scroller_if slave
//           (start/halt/pattern in; grid/probe/passed/step/running/dbg_state out)
module pipe_scroller #(
    parameter int TICK_DIV     = 4,
    parameter int PIPE_SPACING = 4,
    parameter int COLS         = 8
) (
    input  logic            Clock,
    input  logic            reset,
    pipe_scroller_if.slave  bus
);

    localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int SW = (PIPE_SPACING > 1) ? $clog2(PIPE_SPACING) : 1;
    localparam logic [TW-1:0] TICK_LAST  = TW'(TICK_DIV - 1);
    localparam logic [SW-1:0] SPACE_LAST = SW'(PIPE_SPACING - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } state_t;

    state_t              state, next_state;
    logic [8*COLS-1:0]   grid_q;
    logic [TW-1:0]       tick_cnt;
    logic [SW-1:0]       space_cnt;
    logic                passed_q, step_q, running_q;

    // Control strobes produced by the output process
    logic                clear_game;   // fresh game on entry to RUN
    logic                advance;      // a RUN cycle that is not halted
    logic                do_step;      // advance on the last tick of a step
    logic [7:0]          new_col;

    // State register
    always_ff @(posedge Clock) begin
        if (reset) state <= IDLE;
        else       state <= next_state;
    end

    // Next-state logic
    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (bus.start) next_state = RUN;
            RUN:     if (bus.halt)  next_state = HALT;   // halt beats start here
            HALT:    if (bus.start) next_state = RUN;
            default: next_state = IDLE;
        endcase
    end

    // Output / control decode
    always_comb begin
        clear_game = 1'b0;
        advance    = 1'b0;
        do_step    = 1'b0;
        new_col    = 8'h00;
        if (state != RUN && bus.start) clear_game = 1'b1;
        // halt suppresses any step due in the same cycle
        if (state == RUN && !bus.halt) begin
            advance = 1'b1;
            do_step = (tick_cnt == TICK_LAST);
        end
        if (space_cnt == '0) new_col = bus.pattern;
    end

    // Playfield datapath and registered pulses
    always_ff @(posedge Clock) begin
        if (reset) begin
            grid_q    <= '0;
            tick_cnt  <= '0;
            space_cnt <= '0;
            passed_q  <= 1'b0;
            step_q    <= 1'b0;
            running_q <= 1'b0;
        end else begin
            passed_q  <= 1'b0;
            step_q    <= 1'b0;
            running_q <= (next_state == RUN);
            if (clear_game) begin
                grid_q    <= '0;
                tick_cnt  <= '0;
                space_cnt <= '0;
            end else if (advance) begin
                if (do_step) begin
                    tick_cnt  <= '0;
                    // column 0 sits in the low byte, so shifting right moves
                    // every column one place to the left on screen
                    grid_q    <= {new_col, grid_q[8*COLS-1:8]};
                    space_cnt <= (space_cnt == SPACE_LAST) ? '0 : space_cnt + 1'b1;
                    passed_q  <= (grid_q[7:0] != 8'h00);
                    step_q    <= 1'b1;
                end else begin
                    tick_cnt <= tick_cnt + 1'b1;
                end
            end
        end
    end

    assign bus.grid      = grid_q;
    assign bus.probe     = grid_q[7:0];
    assign bus.passed    = passed_q;
    assign bus.step      = step_q;
    assign bus.running   = running_q;
    assign bus.dbg_state = state;

endmodule

// File: tb/tb_pipe_scroller.sv
module tb_pipe_scroller;

    localparam int TICK_DIV     = 4;
    localparam int PIPE_SPACING = 4;
    localparam int COLS         = 8;
    localparam int GW           = 8 * COLS;

    logic Clock;
    logic reset;

    pipe_scroller_if #(.COLS(COLS)) bus ();

    pipe_scroller #(
        .TICK_DIV    (TICK_DIV),
        .PIPE_SPACING(PIPE_SPACING),
        .COLS        (COLS)
    ) dut (
        .Clock (Clock),
        .reset (reset),
        .bus   (bus)
    );

    // ---------------- clock ----------------
    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    // ---------------- scoreboard / reference model ----------------
    // exp_q holds every column injected since the current game began, oldest
    // first. After n steps the visible window is the last COLS of them.
    logic [7:0] exp_q[$];
    int         m_mode;      // 0 idle, 1 run, 2 halt
    int         m_edges;     // unhalted RUN edges since the game started
    logic       m_passed, m_step;

    int n_checks = 0;
    int n_bad    = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [GW-1:0] model_grid();
        logic [GW-1:0] g;
        int idx;
        g = '0;
        for (int i = 0; i < COLS; i++) begin
            idx = exp_q.size() - COLS + i;
            if (idx >= 0) g[8*i +: 8] = exp_q[idx];
        end
        return g;
    endfunction

    // Apply one clock edge to the model using the inputs presented at that edge
    task automatic model_edge();
        int   n;
        logic [7:0] old0;
        m_passed = 1'b0;
        m_step   = 1'b0;
        if (reset) begin
            m_mode  = 0;
            m_edges = 0;
            exp_q.delete();
        end else begin
            case (m_mode)
                0, 2: if (bus.start) begin
                    m_mode  = 1;
                    m_edges = 0;
                    exp_q.delete();
                end
                default: if (bus.halt) begin
                    m_mode = 2;
                end else begin
                    m_edges++;
                    if (m_edges % TICK_DIV == 0) begin
                        n    = exp_q.size();
                        old0 = (n >= COLS) ? exp_q[n-COLS] : 8'h00;
                        m_passed = (old0 != 8'h00);
                        exp_q.push_back((n % PIPE_SPACING == 0) ? bus.pattern : 8'h00);
                        m_step = 1'b1;
                    end
                end
            endcase
        end
    endtask

    task automatic compare_all();
        logic [GW-1:0] g;
        g = model_grid();
        check("grid",    64'(bus.grid),    64'(g));
        check("probe",   64'(bus.probe),   64'(g[7:0]));
        check("passed",  64'(bus.passed),  64'(m_passed));
        check("step",    64'(bus.step),    64'(m_step));
        check("running", 64'(bus.running), 64'(m_mode == 1));
    endtask

    // ---------------- driver ----------------
    // Inputs change on the falling edge; outputs are checked on the next
    // falling edge after the rising edge that consumed them.
    task automatic cycle(input logic rst, input logic st, input logic hl, input logic [7:0] pat);
        reset       = rst;
        bus.start   = st;
        bus.halt    = hl;
        bus.pattern = pat;
        @(posedge Clock);
        model_edge();
        @(negedge Clock);
        compare_all();
    endtask

    function automatic logic [7:0] col7();
        return bus.grid[8*(COLS-1) +: 8];
    endfunction

    // ---------------- stimulus ----------------
    initial begin
        logic [7:0] pat;
        m_mode = 0; m_edges = 0; m_passed = 1'b0; m_step = 1'b0;
        reset = 1'b1; bus.start = 1'b0; bus.halt = 1'b0; bus.pattern = 8'h00;
        @(negedge Clock);

        // Reset, then idle
        for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, 1'b0, 8'h00);
        check("reset_grid", 64'(bus.grid), 64'h0);
        for (int i = 0; i < 20; i++) begin
            cycle(1'b0, 1'b0, 1'b0, 8'($urandom_range(0, 255)));
            check("idle_running", 64'(bus.running), 64'h0);
        end

        // Steady pattern 1F from E0
        cycle(1'b0, 1'b1, 1'b0, 8'h1F);
        check("e0_running", 64'(bus.running), 64'h1);
        for (int i = 1; i <= 55; i++) begin
            cycle(1'b0, 1'b0, 1'b0, 8'h1F);
            if (i == 4)  check("col7_e4",  64'(col7()), 64'h1F);
            if (i == 4)  check("step_e4",  64'(bus.step), 64'h1);
            if (i == 5)  check("step_e5",  64'(bus.step), 64'h0);
            if (i == 8)  check("col7_e8",  64'(col7()), 64'h00);
            if (i == 12) check("col7_e12", 64'(col7()), 64'h00);
            if (i == 16) check("col7_e16", 64'(col7()), 64'h00);
            if (i == 20) check("col7_e20", 64'(col7()), 64'h1F);
            if (i == 28) check("probe_e28", 64'(bus.probe), 64'h00);
            if (i == 32) check("probe_e32", 64'(bus.probe), 64'h1F);
            if (i == 35) check("passed_e35", 64'(bus.passed), 64'h0);
            if (i == 36) check("passed_e36", 64'(bus.passed), 64'h1);
            if (i == 37) check("passed_e37", 64'(bus.passed), 64'h0);
            if (i == 52) check("passed_e52", 64'(bus.passed), 64'h1);
        end

        // Halt on the edge where a step is due (E0+56)
        cycle(1'b0, 1'b0, 1'b1, 8'h1F);
        check("halt_step",   64'(bus.step),    64'h0);
        check("halt_passed", 64'(bus.passed),  64'h0);
        check("halt_run",    64'(bus.running), 64'h0);
        for (int i = 0; i < 50; i++) cycle(1'b0, 1'b0, $urandom_range(0, 1) == 1, 8'($urandom_range(0, 255)));

        // Restart from HALT
        cycle(1'b0, 1'b1, 1'b0, 8'hA5);
        check("restart_grid", 64'(bus.grid),    64'h0);
        check("restart_run",  64'(bus.running), 64'h1);
        for (int i = 1; i <= 4; i++) cycle(1'b0, 1'b0, 1'b0, 8'hA5);
        check("restart_col7", 64'(col7()), 64'hA5);

        // Fill the field, then reset mid-run
        for (int i = 0; i < 40; i++) cycle(1'b0, $urandom_range(0, 1) == 1, 1'b0, 8'($urandom_range(1, 255)));
        cycle(1'b1, 1'b0, 1'b0, 8'h77);
        check("midreset_grid", 64'(bus.grid), 64'h0);
        check("midreset_run",  64'(bus.running), 64'h0);

        // Empty injections never produce passed
        cycle(1'b0, 1'b1, 1'b0, 8'h00);
        for (int i = 0; i < 100; i++) begin
            cycle(1'b0, 1'b0, 1'b0, 8'h00);
            check("empty_passed", 64'(bus.passed), 64'h0);
        end

        // Randomized play
        for (int i = 0; i < 3000; i++) begin
            pat = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom_range(1, 255));
            cycle($urandom_range(0, 499) == 0,
                  $urandom_range(0, 19) == 0,
                  $urandom_range(0, 99) == 0,
                  pat);
        end

        $display("test done: total=%0d bad=%0d", n_checks, n_bad);
        $finish;
    end

endmodule
